// File: rtl/fifo_ctrl_param.sv
// rtl/fifo_ctrl_param.sv - parametrised single-clock FIFO controller for a synchronous-read memory
module fifo_ctrl_param #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              flush,
   input  logic              err_clr,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   level,
   output logic [ADDR_W:0]   max_level,
   output logic              overflow,
   output logic              underflow,
   output logic              rd_valid,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_V    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_V    = (ADDR_W + 1)'(AE_LEVEL);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [ADDR_W:0] wr_ptr_nxt;
   logic [ADDR_W:0] rd_ptr_nxt;
   logic [ADDR_W:0] level_nxt;
   logic            ovf_set;
   logic            udf_set;

   // Status flags come only from the registered pointers, never from this cycle's requests.
   assign level        = wr_ptr - rd_ptr;
   assign full         = (level == DEPTH_V);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AF_V);
   assign almost_empty = (level <= AE_V);

   // Flush suppresses both strobes so the memory is not touched while clearing.
   assign mem_wr_en   = wr_en & ~full & ~flush;
   assign mem_rd_en   = rd_en & ~empty & ~flush;
   assign mem_wr_addr = wr_ptr[ADDR_W-1:0];
   assign mem_rd_addr = rd_ptr[ADDR_W-1:0];

   assign ovf_set = wr_en & full & ~flush;
   assign udf_set = rd_en & empty & ~flush;

   // Next pointer values; flush takes priority over any accepted transfer.
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (mem_wr_en) wr_ptr_nxt = wr_ptr + PTR_ONE;
         if (mem_rd_en) rd_ptr_nxt = rd_ptr + PTR_ONE;
      end
   end

   assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set | (overflow & ~err_clr);
         underflow <= udf_set | (underflow & ~err_clr);
      end
   end

   // High-water mark; err_clr restarts tracking from the present occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_level <= '0;
      end else if (err_clr) begin
         max_level <= level;
      end else if (level_nxt > max_level) begin
         max_level <= level_nxt;
      end
   end

   // Read data from the synchronous memory appears one cycle after the read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= mem_rd_en;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb/tb_fifo_ctrl_param.sv - randomized self-checking bench for fifo_ctrl_param
module tb_fifo_ctrl_param;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic       full, empty, almost_full, almost_empty;
   logic [4:0] level, max_level;
   logic       overflow, underflow, rd_valid;
   logic       mem_wr_en, mem_rd_en;
   logic [3:0] mem_wr_addr, mem_rd_addr;

   logic       s_wr_en = 1'b0, s_rd_en = 1'b0, s_flush = 1'b0, s_err_clr = 1'b0;
   logic       s_full, s_empty, s_almost_full, s_almost_empty;
   logic [3:0] s_level, s_max_level;
   logic       s_overflow, s_underflow, s_rd_valid;
   logic       s_mem_wr_en, s_mem_rd_en;
   logic [2:0] s_mem_wr_addr, s_mem_rd_addr;

   int checks = 0;
   int errors = 0;

   // reference model: occupancy count, next write/read slot, sticky flags
   int m_level = 0, m_wa = 0, m_ra = 0, m_max = 0;
   bit m_ovf = 0, m_udf = 0, m_rv = 0;

   logic [9:0]  o_strobe, x_strobe;
   logic [16:0] obs_status;
   assign obs_status = {level, max_level, full, empty, almost_full, almost_empty,
                        overflow, underflow, rd_valid};

   always #5 clk = ~clk;

   fifo_ctrl_param dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .level(level), .max_level(max_level),
      .overflow(overflow), .underflow(underflow), .rd_valid(rd_valid),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr)
   );

   fifo_ctrl_param #(.ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .rd_en(s_rd_en), .flush(s_flush),
      .err_clr(s_err_clr), .full(s_full), .empty(s_empty), .almost_full(s_almost_full),
      .almost_empty(s_almost_empty), .level(s_level), .max_level(s_max_level),
      .overflow(s_overflow), .underflow(s_underflow), .rd_valid(s_rd_valid),
      .mem_wr_en(s_mem_wr_en), .mem_wr_addr(s_mem_wr_addr), .mem_rd_en(s_mem_rd_en),
      .mem_rd_addr(s_mem_rd_addr)
   );

   function automatic logic [16:0] exp_status();
      return {5'(m_level), 5'(m_max), m_level == D, m_level == 0, m_level >= 14,
              m_level <= 2, m_ovf, m_udf, m_rv};
   endfunction

   function automatic void model_reset();
      m_level = 0; m_wa = 0; m_ra = 0; m_max = 0;
      m_ovf = 0; m_udf = 0; m_rv = 0;
   endfunction

   // one clock: drive at negedge, sample strobes, advance model at posedge, return at next negedge
   task automatic cycle(input bit w, input bit r, input bit f, input bit e);
      bit x_wen, x_ren;
      int old;
      wr_en = w; rd_en = r; flush = f; err_clr = e;
      #1;
      o_strobe = {mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr};
      x_wen = w && (m_level != D) && !f;
      x_ren = r && (m_level != 0) && !f;
      x_strobe = {x_wen, 4'(m_wa), x_ren, 4'(m_ra)};
      @(posedge clk);
      old = m_level;
      if (w && m_level == D && !f) m_ovf = 1; else if (e) m_ovf = 0;
      if (r && m_level == 0 && !f) m_udf = 1; else if (e) m_udf = 0;
      if (f) begin
         m_level = 0; m_wa = 0; m_ra = 0;
      end else begin
         m_level = m_level + int'(x_wen) - int'(x_ren);
         m_wa = (m_wa + int'(x_wen)) % D;
         m_ra = (m_ra + int'(x_ren)) % D;
      end
      if (e) m_max = old;
      else if (m_level > m_max) m_max = m_level;
      m_rv = x_ren;
      @(negedge clk);
      wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (obs_status !== 17'b00000_00000_0_1_0_1_0_0_0) begin
         errors++;
         $display("FAIL reset_status got %h exp %h", obs_status, 17'b00000_00000_0_1_0_1_0_0_0);
      end
      checks++;
      if ({mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr} !== 10'd0) begin
         errors++;
         $display("FAIL reset_strobes got %h exp 000", {mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr});
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 17; i++) begin
         cycle(1, 0, 0, 0);
         checks++;
         if (o_strobe !== x_strobe || (i < 16 && o_strobe[8:5] !== 4'(i))) begin
            errors++;
            $display("FAIL fill_strobe i=%0d got %h exp %h", i, o_strobe, x_strobe);
         end
         checks++;
         if (obs_status !== exp_status()) begin
            errors++;
            $display("FAIL fill_status i=%0d got %h exp %h", i, obs_status, exp_status());
         end
      end
      checks++;
      if (level !== 5'd16 || overflow !== 1'b1 || max_level !== 5'd16) begin
         errors++;
         $display("FAIL fill_overflow got level=%0d ovf=%b max=%0d exp 16 1 16", level, overflow, max_level);
      end
   endtask

   task automatic test_full_rw();
      cycle(1, 1, 0, 0);
      checks++;
      if (o_strobe !== x_strobe || mem_rd_addr !== 4'd1) begin
         errors++;
         $display("FAIL full_rw_strobe got %h exp %h", o_strobe, x_strobe);
      end
      checks++;
      if (obs_status !== exp_status() || level !== 5'd15 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_status got %h exp %h", obs_status, exp_status());
      end
      for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);
      checks++;
      if (obs_status !== exp_status() || empty !== 1'b1) begin
         errors++;
         $display("FAIL drain_status got %h exp %h", obs_status, exp_status());
      end
   endtask

   task automatic test_empty();
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      checks++;
      if (o_strobe[4] !== 1'b0 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_rd got ren=%b udf=%b rv=%b exp 0 1 0", o_strobe[4], underflow, rd_valid);
      end
      cycle(1, 1, 0, 0);
      checks++;
      if (obs_status !== exp_status() || level !== 5'd1 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw got %h exp %h", obs_status, exp_status());
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 0, 0);
         checks++;
         if (o_strobe !== x_strobe) begin
            errors++;
            $display("FAIL wrap_strobe i=%0d got %h exp %h", i, o_strobe, x_strobe);
         end
         checks++;
         if (obs_status !== exp_status() || level !== 5'd5 || full || empty || almost_empty) begin
            errors++;
            $display("FAIL wrap_status i=%0d got %h exp %h", i, obs_status, exp_status());
         end
      end
   endtask

   task automatic test_flush();
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      checks++;
      if (o_strobe[9] !== 1'b0 || o_strobe[4] !== 1'b0) begin
         errors++;
         $display("FAIL flush_strobe got wen=%b ren=%b exp 0 0", o_strobe[9], o_strobe[4]);
      end
      checks++;
      if (obs_status !== exp_status() || max_level !== 5'd9 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_status got %h exp %h", obs_status, exp_status());
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0 || max_level !== 5'd0) begin
         errors++;
         $display("FAIL err_clr got ovf=%b udf=%b max=%0d exp 0 0 0", overflow, underflow, max_level);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bit w, r, f, e;
         w = (i < 300) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
         r = (i < 300) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 70);
         f = ($urandom_range(0, 47) == 0);
         e = ($urandom_range(0, 63) == 0);
         cycle(w, r, f, e);
         checks++;
         if (o_strobe !== x_strobe) begin
            errors++;
            $display("FAIL rand_strobe i=%0d got %h exp %h", i, o_strobe, x_strobe);
         end
         checks++;
         if (obs_status !== exp_status()) begin
            errors++;
            $display("FAIL rand_status i=%0d got %h exp %h", i, obs_status, exp_status());
         end
      end
   endtask

   task automatic test_async_reset();
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (obs_status !== exp_status() || {mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr} !== 10'd0) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", obs_status, exp_status());
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_small();
      for (int i = 0; i < 9; i++) begin
         s_wr_en = 1;
         #1;
         checks++;
         if (s_mem_wr_en !== (i < 8) || (i < 8 && s_mem_wr_addr !== 3'(i))) begin
            errors++;
            $display("FAIL small_wr i=%0d got wen=%b addr=%0d exp %b %0d", i, s_mem_wr_en, s_mem_wr_addr, i < 8, i);
         end
         @(negedge clk);
         s_wr_en = 0;
         checks++;
         if (s_level !== 4'((i < 8) ? i + 1 : 8) || s_almost_full !== (i + 1 >= 6) ||
             s_full !== (i + 1 >= 8) || s_almost_empty !== (i + 1 <= 1) || s_overflow !== (i == 8)) begin
            errors++;
            $display("FAIL small_status i=%0d got lvl=%0d af=%b f=%b ae=%b ovf=%b", i, s_level,
                     s_almost_full, s_full, s_almost_empty, s_overflow);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_fill();
      test_full_rw();
      test_empty();
      test_wrap();
      test_flush();
      test_random();
      test_async_reset();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
